// File: rtl/wide_subtractor_pipe_if.sv
// Operand/result handshake bundle for wide_subtractor_pipe.
// The ovf wire exists only when WIDE_SUB_OVF_EN is defined.
interface wide_subtractor_pipe_if #(
    parameter int SUB_SIZE = 1024
);
    logic                in_valid;
    logic                in_ready;
    logic [SUB_SIZE-1:0] A;
    logic [SUB_SIZE-1:0] B;
    logic                bin;
    logic                out_valid;
    logic                out_ready;
    logic [SUB_SIZE-1:0] diff;
    logic                bout;
`ifdef WIDE_SUB_OVF_EN
    logic                ovf;
`endif

    modport master (
        output in_valid, A, B, bin, out_ready,
`ifdef WIDE_SUB_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, A, B, bin, out_ready,
`ifdef WIDE_SUB_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/wide_subtractor_pipe.sv
// Pipelined wide subtractor: diff = A - B - bin, borrow chain cut into STAGES slices.
// Define WIDE_SUB_OVF_EN to add the registered signed-overflow output ovf.
module wide_subtractor_pipe #(
    parameter int SUB_SIZE = 1024,  // must be a multiple of 8*STAGES
    parameter int STAGES   = 4      // at least 2
) (
    input  logic                   clk,
    input  logic                   reset,
    wide_subtractor_pipe_if.slave  bus
);
    localparam int SLICE = SUB_SIZE / STAGES;
    // Triangular packing: stage k keeps (STAGES-1-k) operand slices and k+1 result slices.
    localparam int TRI = SLICE * STAGES * (STAGES - 1) / 2;

    logic [TRI-1:0]      a_q, b_q, lo_q;
    wire  [TRI-1:0]      a_d, b_d, lo_d;
    wire  [STAGES-1:0]   carry_d;
    logic [STAGES-2:0]   carry_q;
    wire  [SUB_SIZE-1:0] diff_d;
    logic [SUB_SIZE-1:0] diff_q;
    logic                bout_q;
    logic [STAGES:1]     vld_pipe;
    logic                advance;
`ifdef WIDE_SUB_OVF_EN
    wire                 ovf_d;
    logic                ovf_q;
`endif

    assign advance = ~vld_pipe[STAGES] | bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [SLICE-1:0] a_s, b_s, s;
        logic             cin;

        if (k == 0) begin : g_src
            assign a_s = bus.A[SLICE-1:0];
            assign b_s = bus.B[SLICE-1:0];
            assign cin = ~bus.bin;
        end else begin : g_skew
            localparam int PO = SLICE * ((k-1)*(STAGES-1) - (k-1)*(k-2)/2);
            assign a_s = a_q[PO +: SLICE];
            assign b_s = b_q[PO +: SLICE];
            assign cin = carry_q[k-1];
        end

        // Subtract as A + ~B + carry; carry out of the slice is the inverted borrow.
        assign {carry_d[k], s} = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE{1'b0}}, cin};

        if (k < STAGES-1) begin : g_mid
            localparam int HO = SLICE * (k*(STAGES-1) - k*(k-1)/2);
            localparam int HW = SLICE * (STAGES-1-k);
            localparam int LO = SLICE * k * (k+1) / 2;
            if (k == 0) begin : g_first
                assign a_d[HO +: HW]     = bus.A[SUB_SIZE-1:SLICE];
                assign b_d[HO +: HW]     = bus.B[SUB_SIZE-1:SLICE];
                assign lo_d[LO +: SLICE] = s;
            end else begin : g_rest
                localparam int PO = SLICE * ((k-1)*(STAGES-1) - (k-1)*(k-2)/2);
                localparam int PL = SLICE * (k-1) * k / 2;
                assign a_d[HO +: HW]           = a_q[PO+SLICE +: HW];
                assign b_d[HO +: HW]           = b_q[PO+SLICE +: HW];
                assign lo_d[LO +: SLICE*(k+1)] = {s, lo_q[PL +: SLICE*k]};
            end
        end else begin : g_last
            localparam int PL = SLICE * (k-1) * k / 2;
            assign diff_d = {s, lo_q[PL +: SLICE*k]};
`ifdef WIDE_SUB_OVF_EN
            // Top slice of A and B still rides the skew pipeline, so the MSBs are at hand here.
            assign ovf_d = (a_s[SLICE-1] ^ b_s[SLICE-1]) & (a_s[SLICE-1] ^ s[SLICE-1]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            lo_q     <= '0;
            carry_q  <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef WIDE_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
            a_q      <= a_d;
            b_q      <= b_d;
            lo_q     <= lo_d;
            carry_q  <= carry_d[STAGES-2:0];
            diff_q   <= diff_d;
            bout_q   <= ~carry_d[STAGES-1];
`ifdef WIDE_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = advance & ~reset;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
`ifdef WIDE_SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_wide_subtractor_pipe.sv
// Directed and scoreboarded checks for wide_subtractor_pipe at SUB_SIZE=32, STAGES=4.
// ovf checks are compiled in only when WIDE_SUB_OVF_EN is defined.
module tb_wide_subtractor_pipe;
    localparam int W   = 32;
    localparam int STG = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wide_subtractor_pipe_if #(.SUB_SIZE(W)) bus ();
    wide_subtractor_pipe #(.SUB_SIZE(W), .STAGES(STG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];  // {ovf, bout, diff}

    // Reference: unsigned 33-bit difference for borrow, sign-extended difference for overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        logic [W:0] r, sr;
        r  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        sr = {a[W-1], a} - {b[W-1], b} - {{W{1'b0}}, bi};
        return {sr[W] ^ sr[W-1], r[W], r[W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, score any output handshake, record any accept, advance one edge.
    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic ordy, output logic took, output logic acc);
        logic [W+1:0] e;
        bus.in_valid  = iv;
        bus.A         = a;
        bus.B         = b;
        bus.bin       = bi;
        bus.out_ready = ordy;
        #1;
        took = bus.out_valid & ordy;
        acc  = iv & bus.in_ready;
        if (took) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(bus.out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_diff", 64'(bus.diff), 64'(e[W-1:0]));
                chk("sb_bout", 64'(bus.bout), 64'(e[W]));
`ifdef WIDE_SUB_OVF_EN
                chk("sb_ovf", 64'(bus.ovf), 64'(e[W+1]));
`endif
            end
        end
        if (acc) exp_q.push_back(model(a, b, bi));
        @(posedge clk);
        #1;
    endtask

    // Single isolated set with hand-computed result; also measures accept-to-valid latency.
    task automatic send_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                            input logic [W-1:0] ed, input logic eb, input logic eo);
        int lat;
        bus.in_valid  = 1'b1;
        bus.A         = a;
        bus.B         = b;
        bus.bin       = bi;
        bus.out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(STG));
        chk({tag, "_diff"}, 64'(bus.diff), 64'(ed));
        chk({tag, "_bout"}, 64'(bus.bout), 64'(eb));
`ifdef WIDE_SUB_OVF_EN
        chk({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
`else
        if (eo) begin end
`endif
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, 64'(bus.out_valid), 64'(0));
    endtask

    initial begin
        logic took, acc, iv, ordy, sb;
        logic [W-1:0] ra, rb, sd;
        int first, last, n, sent, recv;

        bus.in_valid  = 1'b1;
        bus.A         = 32'hDEAD_BEEF;
        bus.B         = 32'h1;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_diff", 64'(bus.diff), 64'(0));
        chk("rst_bout", 64'(bus.bout), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
`ifdef WIDE_SUB_OVF_EN
        chk("rst_ovf", 64'(bus.ovf), 64'(0));
`endif
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        send_one("d5m3",   32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 1'b0);
        send_one("d0m1",   32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send_one("eq_bin", 32'h1234_5678,  32'h1234_5678,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send_one("off1",   32'h1234_5678,  32'h1234_5677,  1'b1, 32'h0000_0000, 1'b0, 1'b0);
        send_one("zmax",   32'h0,          32'hFFFF_FFFF,  1'b1, 32'h0000_0000, 1'b1, 1'b0);
        send_one("sovf",   32'h8000_0000,  32'h1,          1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);

        // Eight back-to-back sets must come out as eight consecutive valid cycles.
        first = -1; last = -1; n = 0;
        for (int i = 0; i < 20; i++) begin
            step(i < 8, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, took, acc);
            if (took) begin
                if (first < 0) first = i;
                last = i;
                n++;
            end
        end
        chk("b2b_count", 64'(n), 64'(8));
        chk("b2b_contig", 64'(last - first + 1), 64'(8));

        // Fill the pipe, then stall the sink for three cycles.
        for (int i = 0; i < 6; i++)
            step(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, took, acc);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.A         = $urandom;
        bus.B         = $urandom;
        #1;
        chk("stall_valid", 64'(bus.out_valid), 64'(1));
        sd = bus.diff;
        sb = bus.bout;
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
            @(posedge clk);
            #1;
            chk("stall_hold_valid", 64'(bus.out_valid), 64'(1));
            chk("stall_hold_diff", 64'(bus.diff), 64'(sd));
            chk("stall_hold_bout", 64'(bus.bout), 64'(sb));
        end
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, took, acc);
            n++;
        end
        chk("stall_drained", 64'(exp_q.size()), 64'(0));

        // Reset with three sets in flight: none may ever emerge.
        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom, $urandom, 1'b0, 1'b1, took, acc);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_diff", 64'(bus.diff), 64'(0));
        chk("midrst_bout", 64'(bus.bout), 64'(0));
        exp_q.delete();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, took, acc);
            if (took) n++;
        end
        chk("midrst_no_stale", 64'(n), 64'(0));

        // Random traffic with random sink throttling and input bubbles.
        sent = 0; recv = 0; n = 0;
        while ((sent < 300 || exp_q.size() > 0) && n < 5000) begin
            iv   = (sent < 300) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            ra   = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       begin ra = 32'($urandom_range(0, 3)); rb = $urandom; end
                default: rb = $urandom;
            endcase
            step(iv, ra, rb, 1'($urandom_range(0, 1)), ordy, took, acc);
            if (acc) sent++;
            if (took) recv++;
            n++;
        end
        chk("rand_received", 64'(recv), 64'(300));
        chk("rand_leftover", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
